fetch_predict_unit: RTL and testbench

- IF-stage PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters.
- Consumes the hazard unit's control outputs: pc_write, stall_IFID, flush_IFID, flush_IDEX.
- Produces the hazard unit's control-hazard inputs: jump_miss and i_branch_miss.
- Tracks each prediction through IF/ID and ID/EX, detects mispredictions in ID (jumps) and EX (conditional branches), and redirects the PC.

---
 rtl/fetch_predict_unit_if.sv | 42 ++++
 rtl/fetch_predict_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_predict_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_predict_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predict_unit_if
// Description : Bundle between the fetch/predict unit and the rest of the
//               pipeline: hazard-unit controls, ID/EX resolution inputs,
//               and the PC / miss outputs.
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_predict_unit_if #(
  parameter int WORD_SIZE = 16
);
  logic                 pc_write;
  logic                 stall_IFID;
  logic                 flush_IFID;
  logic                 flush_IDEX;
  logic                 is_jump_ID;
  logic [WORD_SIZE-1:0] jump_target_ID;
  logic                 is_branch_EX;
  logic                 branch_taken_EX;
  logic [WORD_SIZE-1:0] branch_target_EX;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] pc_ID;
  logic                 jump_miss;
  logic                 i_branch_miss;

  // Pipeline / hazard side: drives controls and resolution, sees PC and misses.
  modport master (
    output pc_write, stall_IFID, flush_IFID, flush_IDEX,
    output is_jump_ID, jump_target_ID,
    output is_branch_EX, branch_taken_EX, branch_target_EX,
    input  i_address, pc_ID, jump_miss, i_branch_miss
  );

  // Fetch/predict unit side.
  modport slave (
    input  pc_write, stall_IFID, flush_IFID, flush_IDEX,
    input  is_jump_ID, jump_target_ID,
    input  is_branch_EX, branch_taken_EX, branch_target_EX,
    output i_address, pc_ID, jump_miss, i_branch_miss
  );
endinterface
`default_nettype wire

// File: rtl/fetch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predict_unit
// Description : IF-stage PC generator. Predicts the next PC from a
//               direct-mapped BTB with 2-bit saturating counters, carries
//               each prediction through IF/ID and ID/EX, flags jump
//               mispredictions in ID and branch mispredictions in EX, and
//               redirects the PC on a miss.
// Option      : define BTB_PREDICT_EN to build the BTB; when undefined the
//               unit always predicts pc+1 and holds no BTB storage.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_predict_unit #(
  parameter int WORD_SIZE    = 16,
  parameter int BTB_IDX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_predict_unit_if.slave   bus
);

  localparam int TAG_BITS = WORD_SIZE - BTB_IDX_BITS;

  // Architectural PC and the two prediction-tracking pipeline registers.
  logic [WORD_SIZE-1:0] pc;
  logic                 valid_id;
  logic [WORD_SIZE-1:0] pc_id;
  logic [WORD_SIZE-1:0] pred_id;
  logic                 valid_ex;
  logic [WORD_SIZE-1:0] pc_ex;
  logic [WORD_SIZE-1:0] pred_ex;

  logic [WORD_SIZE-1:0] pc_plus1;
  logic [WORD_SIZE-1:0] pred_next;
  logic [WORD_SIZE-1:0] correct_ex;
  logic                 branch_miss;
  logic                 jmp_miss;

  assign pc_plus1   = pc + WORD_SIZE'(1);
  assign correct_ex = bus.branch_taken_EX ? bus.branch_target_EX
                                          : pc_ex + WORD_SIZE'(1);

  // A branch miss in EX means the ID instruction is on the wrong path, so it
  // must neither redirect the PC nor train the BTB.
  assign branch_miss = valid_ex && bus.is_branch_EX && (correct_ex != pred_ex);
  assign jmp_miss    = valid_id && bus.is_jump_ID &&
                       (bus.jump_target_ID != pred_id) && !branch_miss;

  assign bus.i_address     = pc;
  assign bus.pc_ID         = pc_id;
  assign bus.jump_miss     = jmp_miss;
  assign bus.i_branch_miss = branch_miss;

`ifdef BTB_PREDICT_EN
  localparam int ENTRIES = 1 << BTB_IDX_BITS;

  logic [ENTRIES-1:0]   btb_valid;
  logic [TAG_BITS-1:0]  btb_tag    [ENTRIES];
  logic [WORD_SIZE-1:0] btb_target [ENTRIES];
  logic [1:0]           btb_ctr    [ENTRIES];

  logic [BTB_IDX_BITS-1:0] idx_if, idx_ex, idx_id;
  logic [TAG_BITS-1:0]     tag_if, tag_ex, tag_id;
  logic                    hit;
  logic                    br_update, br_match, jmp_update, jmp_write;

  assign idx_if = pc[BTB_IDX_BITS-1:0];
  assign tag_if = pc[WORD_SIZE-1:BTB_IDX_BITS];
  assign idx_ex = pc_ex[BTB_IDX_BITS-1:0];
  assign tag_ex = pc_ex[WORD_SIZE-1:BTB_IDX_BITS];
  assign idx_id = pc_id[BTB_IDX_BITS-1:0];
  assign tag_id = pc_id[WORD_SIZE-1:BTB_IDX_BITS];

  assign hit       = btb_valid[idx_if] && (btb_tag[idx_if] == tag_if);
  assign pred_next = (hit && btb_ctr[idx_if][1]) ? btb_target[idx_if] : pc_plus1;

  assign br_update  = valid_ex && bus.is_branch_EX;
  assign br_match   = btb_valid[idx_ex] && (btb_tag[idx_ex] == tag_ex);
  assign jmp_update = valid_id && bus.is_jump_ID && !branch_miss;
  // On an index collision the resolved EX branch is the older instruction
  // and owns the entry this cycle.
  assign jmp_write  = jmp_update && !(br_update && (idx_id == idx_ex));

  // BTB training: branch counters/targets from EX, jump entries from ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else begin
      if (br_update) begin
        if (br_match) begin
          if (bus.branch_taken_EX) begin
            btb_target[idx_ex] <= bus.branch_target_EX;
            if (btb_ctr[idx_ex] != 2'b11) btb_ctr[idx_ex] <= btb_ctr[idx_ex] + 2'd1;
          end else begin
            if (btb_ctr[idx_ex] != 2'b00) btb_ctr[idx_ex] <= btb_ctr[idx_ex] - 2'd1;
          end
        end else begin
          btb_valid[idx_ex]  <= 1'b1;
          btb_tag[idx_ex]    <= tag_ex;
          btb_target[idx_ex] <= bus.branch_target_EX;
          btb_ctr[idx_ex]    <= bus.branch_taken_EX ? 2'b10 : 2'b01;
        end
      end
      if (jmp_write) begin
        btb_valid[idx_id]  <= 1'b1;
        btb_tag[idx_id]    <= tag_id;
        btb_target[idx_id] <= bus.jump_target_ID;
        btb_ctr[idx_id]    <= 2'b11;
      end
    end
  end
`else
  assign pred_next = pc_plus1;
`endif

  // PC redirect priority plus the IF/ID and ID/EX prediction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      valid_id <= 1'b0;
      pc_id    <= '0;
      pred_id  <= '0;
      valid_ex <= 1'b0;
      pc_ex    <= '0;
      pred_ex  <= '0;
    end else begin
      if (branch_miss)       pc <= correct_ex;
      else if (jmp_miss)     pc <= bus.jump_target_ID;
      else if (bus.pc_write) pc <= pred_next;

      if (bus.flush_IFID) begin
        valid_id <= 1'b0;
      end else if (!bus.stall_IFID) begin
        valid_id <= 1'b1;
        pc_id    <= pc;
        pred_id  <= pred_next;
      end

      // A stalled IF/ID sends a bubble downstream rather than duplicating ID.
      if (bus.flush_IDEX || bus.stall_IFID) begin
        valid_ex <= 1'b0;
      end else begin
        valid_ex <= valid_id;
        pc_ex    <= pc_id;
        pred_ex  <= pred_id;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_predict_unit
// Description : Self-checking bench for fetch_predict_unit. A small program
//               map supplies jumps/branches, a behavioural model predicts
//               PC, pc_ID and miss flags; expectations are queued at drive
//               time and compared when the outputs are sampled.
// Option      : honours BTB_PREDICT_EN like the design.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_predict_unit;

`ifdef BTB_PREDICT_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif
  localparam int NE = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] pid;
    logic        jm;
    logic        bm;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t sb[$];
  bit   taken_q[$];

  fetch_predict_unit_if #(.WORD_SIZE(16)) bus ();

  fetch_predict_unit #(.WORD_SIZE(16), .BTB_IDX_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit          m_bv  [NE];
  logic [11:0] m_tag [NE];
  logic [15:0] m_tgt [NE];
  logic [1:0]  m_ctr [NE];
  logic [15:0] m_pc, m_pc_id, m_pn_id, m_pc_ex, m_pn_ex;
  bit          m_v_id, m_v_ex;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Program map: which addresses hold jumps / conditional branches.
  task automatic prog(input logic [15:0] a, output bit isj, output logic [15:0] jt,
                      output bit isb, output logic [15:0] bt);
    isj = 1'b0; jt = 16'h0; isb = 1'b0; bt = 16'h0;
    case (a)
      16'h0004: begin isj = 1'b1; jt = 16'h0020; end
      16'h0024: begin isj = 1'b1; jt = 16'h0010; end
      16'h0011: begin isj = 1'b1; jt = 16'h0040; end
      16'h0030: begin isj = 1'b1; jt = 16'h0000; end
      16'h0044: begin isj = 1'b1; jt = 16'hFFFE; end
      16'h0010: begin isb = 1'b1; bt = 16'h0030; end
      default:  ;
    endcase
  endtask

  function automatic logic [15:0] m_pred(input logic [15:0] p);
    int i;
    i = int'(p[3:0]);
    if (BTB_ON && m_bv[i] && (m_tag[i] == p[15:4]) && m_ctr[i][1]) return m_tgt[i];
    return p + 16'd1;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_pc_id = '0; m_pn_id = '0; m_pc_ex = '0; m_pn_ex = '0;
    m_v_id = 1'b0; m_v_ex = 1'b0;
    for (int i = 0; i < NE; i++) begin
      m_bv[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b01;
    end
  endtask

  // One cycle: drive at negedge, queue expectation, compare 1ns later,
  // then advance the model to the state after the coming posedge.
  task automatic step(input bit rs, input bit st, input bit pw, input bit xf);
    bit isj, isb, dj, db, tk, jm, bm;
    logic [15:0] jt, bt, djt, dbt, corr, pn;
    int bi, ji;
    exp_t e;
    @(negedge clk);
    prog(m_pc_id, isj, jt, db, dbt);
    prog(m_pc_ex, dj, djt, isb, bt);
    tk = 1'($urandom_range(0, 1));
    if (m_v_ex && isb && taken_q.size() > 0) tk = taken_q.pop_front();
    corr = tk ? bt : m_pc_ex + 16'd1;
    bm   = m_v_ex && isb && (corr != m_pn_ex);
    jm   = m_v_id && isj && (jt != m_pn_id) && !bm;
    pn   = m_pred(m_pc);

    reset                = rs;
    bus.pc_write         = pw;
    bus.stall_IFID       = st;
    bus.flush_IFID       = jm | bm | xf;
    bus.flush_IDEX       = bm;
    bus.is_jump_ID       = isj;
    bus.jump_target_ID   = jt;
    bus.is_branch_EX     = isb;
    bus.branch_taken_EX  = tk;
    bus.branch_target_EX = bt;
    sb.push_back('{addr: m_pc, pid: m_pc_id, jm: jm, bm: bm});

    #1;
    e = sb.pop_front();
    check("i_address",     bus.i_address,            e.addr);
    check("pc_ID",         bus.pc_ID,                e.pid);
    check("jump_miss",     16'(bus.jump_miss),       16'(e.jm));
    check("i_branch_miss", 16'(bus.i_branch_miss),   16'(e.bm));

    if (rs) begin
      model_reset();
    end else begin
      bi = int'(m_pc_ex[3:0]);
      ji = int'(m_pc_id[3:0]);
      if (BTB_ON && m_v_ex && isb) begin
        if (m_bv[bi] && m_tag[bi] == m_pc_ex[15:4]) begin
          if (tk) begin
            m_tgt[bi] = bt;
            m_ctr[bi] = (m_ctr[bi] == 2'b11) ? 2'b11 : m_ctr[bi] + 2'd1;
          end else begin
            m_ctr[bi] = (m_ctr[bi] == 2'b00) ? 2'b00 : m_ctr[bi] - 2'd1;
          end
        end else begin
          m_bv[bi] = 1'b1; m_tag[bi] = m_pc_ex[15:4]; m_tgt[bi] = bt;
          m_ctr[bi] = tk ? 2'b10 : 2'b01;
        end
      end
      if (BTB_ON && m_v_id && isj && !bm && !(m_v_ex && isb && bi == ji)) begin
        m_bv[ji] = 1'b1; m_tag[ji] = m_pc_id[15:4]; m_tgt[ji] = jt; m_ctr[ji] = 2'b11;
      end
      if (bm || st) m_v_ex = 1'b0;
      else begin m_v_ex = m_v_id; m_pc_ex = m_pc_id; m_pn_ex = m_pn_id; end
      if (jm || bm || xf) m_v_id = 1'b0;
      else if (!st) begin m_v_id = 1'b1; m_pc_id = m_pc; m_pn_id = pn; end
      if (bm)      m_pc = corr;
      else if (jm) m_pc = jt;
      else if (pw) m_pc = pn;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.pc_write = 1'b0; bus.stall_IFID = 1'b0; bus.flush_IFID = 1'b0;
    bus.flush_IDEX = 1'b0; bus.is_jump_ID = 1'b0; bus.jump_target_ID = '0;
    bus.is_branch_EX = 1'b0; bus.branch_taken_EX = 1'b0; bus.branch_target_EX = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_i_address", bus.i_address, 16'h0000);
    check("rst_pc_ID",     bus.pc_ID,     16'h0000);
    check("rst_jump_miss", 16'(bus.jump_miss),     16'h0);
    check("rst_br_miss",   16'(bus.i_branch_miss), 16'h0);

    // Straight-line fetch.
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("seq_i_address", bus.i_address, 16'h0003);

    // Jump learning, BEQ taken/taken/not-taken, coincident misses, wrap.
    taken_q.push_back(1'b1);
    taken_q.push_back(1'b1);
    taken_q.push_back(1'b0);
    repeat (90) step(1'b0, 1'b0, 1'b1, 1'b0);

    // Two-cycle stall with the PC held.
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      bit st, pw, xf;
      st = ($urandom_range(0, 5) == 0);
      pw = !st && ($urandom_range(0, 7) != 0);
      xf = ($urandom_range(0, 15) == 0);
      step(i == 200, st, pw, xf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
